// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 request arbiter slice.
package l2_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

  localparam int NUM_REQ_DEF = 2;
  localparam int GRANT_W     = $clog2(NUM_REQ_DEF);

  function automatic int wrap_inc(input int g, input int n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction
endpackage

// File: rtl/l2_request_arbiter_if.sv
// L1-side requester bundle and L2-side port bundle.
interface l1_req_if #(
  parameter int NUM_REQ       = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int L1_BLOCK_SIZE = 16
) ();
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]                    rq_addr;
  logic [NUM_REQ-1:0][L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rq_data_in;
  logic [NUM_REQ-1:0]                                    rq_read;
  logic [NUM_REQ-1:0]                                    rq_write;
  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]              rq_data_out;
  logic [NUM_REQ-1:0]                                    rq_ready;
  logic                                                  rq_hit;

  modport master (output rq_addr, rq_data_in, rq_read, rq_write,
                  input  rq_data_out, rq_ready, rq_hit);
  modport slave  (input  rq_addr, rq_data_in, rq_read, rq_write,
                  output rq_data_out, rq_ready, rq_hit);
endinterface

interface l2_port_if #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int L1_BLOCK_SIZE = 16
) ();
  logic [ADDR_WIDTH-1:0]                    l2_cache_addr;
  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_cache_data_in;
  logic                                     l2_cache_read;
  logic                                     l2_cache_write;
  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_cache_data_out;
  logic                                     l2_cache_ready;
  logic                                     l2_hit;

  modport master (output l2_cache_addr, l2_cache_data_in, l2_cache_read, l2_cache_write,
                  input  l2_cache_data_out, l2_cache_ready, l2_hit);
  modport slave  (input  l2_cache_addr, l2_cache_data_in, l2_cache_read, l2_cache_write,
                  output l2_cache_data_out, l2_cache_ready, l2_hit);
endinterface

// File: rtl/l2_request_arbiter_rr_pick.sv
// Combinational round-robin select: first active requester at or after ptr_i.
module rr_pick import l2_arb_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int GW      = GRANT_W
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GW-1:0]      ptr_i,
  output logic [GW-1:0]      grant_o,
  output logic               any_o
);
  int   idx;
  logic found;

  always_comb begin
    grant_o = '0;
    any_o   = |req_i;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_i) + i) % NUM_REQ;
      if (!found && req_i[idx]) begin
        grant_o = GW'(idx);
        found   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/l2_request_arbiter.sv
// Shares one L2 request port among NUM_REQ L1 requesters, one block transfer at a time.
module l2_request_arbiter import l2_arb_pkg::*; #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int L1_BLOCK_SIZE = 16,
  parameter int NUM_REQ       = NUM_REQ_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  l1_req_if.slave   rq,
  l2_port_if.master l2
);
  localparam int GW = $clog2(NUM_REQ);
  typedef logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] blk_t;

  arb_state_e          state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  blk_t                wdata_q, wdata_d, rdata_q, rdata_d;
  logic                rd_stb_q, rd_stb_d, wr_stb_q, wr_stb_d, hit_q, hit_d, any_req;
  logic [NUM_REQ-1:0]  ready_q, ready_d;

  rr_pick #(.NUM_REQ(NUM_REQ), .GW(GW)) u_pick (
    .req_i   (rq.rq_read | rq.rq_write),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick),
    .any_o   (any_req)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    hit_d    = hit_q;
    rd_stb_d = 1'b0;
    wr_stb_d = 1'b0;
    ready_d  = '0;
    case (state_q)
      IDLE: if (any_req) begin
        // write wins when both levels are high
        grant_d  = pick;
        addr_d   = rq.rq_addr[pick];
        wdata_d  = rq.rq_data_in[pick];
        wr_stb_d = rq.rq_write[pick];
        rd_stb_d = !rq.rq_write[pick];
        state_d  = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (l2.l2_cache_ready) begin
        rdata_d          = l2.l2_cache_data_out;
        hit_d            = l2.l2_hit;
        ready_d[grant_q] = 1'b1;
        rr_ptr_d         = GW'(wrap_inc(int'(grant_q), NUM_REQ));
        state_d          = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      hit_q    <= 1'b0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      ready_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      hit_q    <= hit_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
      ready_q  <= ready_d;
    end
  end

  assign l2.l2_cache_addr    = addr_q;
  assign l2.l2_cache_data_in = wdata_q;
  assign l2.l2_cache_read    = rd_stb_q;
  assign l2.l2_cache_write   = wr_stb_q;
  assign rq.rq_data_out      = rdata_q;
  assign rq.rq_ready         = ready_q;
  assign rq.rq_hit           = hit_q;
endmodule
